// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - trap sequencer driving the CSR unit write port and fetch redirect
// Every write cycle re-drives unchanged CSRs from their dout since the CSR unit writes all five at once.
module trap_ctrl #(
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              exc_ebreak,
  input  logic              exc_div0,
  input  logic              exc_mem,
  input  logic [31:0]       exc_pc,
  input  logic [31:0]       exc_tval,
  input  logic              mret,
  input  logic              sw_we,
  input  logic [11:0]       sw_addr,
  input  logic [31:0]       sw_wdata,
  input  logic [31:0]       mtevc_dout,
  input  logic [31:0]       mcause_dout,
  input  logic [31:0]       mepc_dout,
  input  logic [31:0]       mtval_dout,
  input  logic [31:0]       mipd_dout,
  output logic              csr_we,
  output logic [31:0]       mtevc_din,
  output logic [31:0]       mcause_din,
  output logic [31:0]       mepc_din,
  output logic [31:0]       mtval_din,
  output logic [31:0]       mipd_din,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  output logic              flush,
  output logic              busy,
  output logic              in_handler,
  output logic [DROP_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {IDLE, ENTER, HANDLER, RET} state_t;

  localparam logic [11:0] ADDR_MTEVC  = 12'h305;
  localparam logic [11:0] ADDR_MCAUSE = 12'h342;
  localparam logic [11:0] ADDR_MEPC   = 12'h341;
  localparam logic [11:0] ADDR_MTVAL  = 12'h343;
  localparam logic [11:0] ADDR_MIPD   = 12'h100;

  state_t      state;
  logic [31:0] lat_code;
  logic [31:0] lat_pc;
  logic [31:0] lat_tval;
  logic        any_exc;
  logic [31:0] exc_code;
  logic        addr_hit;
  logic        do_sw;

  assign any_exc = exc_ebreak | exc_div0 | exc_mem;

  always_comb begin
    if (exc_mem)       exc_code = 32'd3;
    else if (exc_div0) exc_code = 32'd2;
    else               exc_code = 32'd1;
  end

  always_comb begin
    case (sw_addr)
      ADDR_MTEVC, ADDR_MCAUSE, ADDR_MEPC, ADDR_MTVAL, ADDR_MIPD: addr_hit = 1'b1;
      default: addr_hit = 1'b0;
    endcase
  end

  // A same-cycle exception in IDLE wins over the software write.
  assign do_sw = rstn && sw_we && addr_hit &&
                 (((state == IDLE) && !any_exc) || (state == HANDLER));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      lat_code <= '0;
      lat_pc   <= '0;
      lat_tval <= '0;
      drop_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_exc) begin
            lat_code <= exc_code;
            lat_pc   <= exc_pc;
            lat_tval <= exc_tval;
            state    <= ENTER;
          end
        end
        ENTER: state <= HANDLER;
        HANDLER: begin
          if (any_exc && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
          if (mret) state <= RET;
        end
        RET: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    csr_we         = 1'b0;
    mtevc_din      = mtevc_dout;
    mcause_din     = mcause_dout;
    mepc_din       = mepc_dout;
    mtval_din      = mtval_dout;
    mipd_din       = mipd_dout;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    flush          = 1'b0;

    if (do_sw) begin
      csr_we = 1'b1;
      case (sw_addr)
        ADDR_MTEVC:  mtevc_din  = sw_wdata;
        ADDR_MCAUSE: mcause_din = sw_wdata;
        ADDR_MEPC:   mepc_din   = sw_wdata;
        ADDR_MTVAL:  mtval_din  = sw_wdata;
        ADDR_MIPD:   mipd_din   = sw_wdata;
        default: ;
      endcase
    end

    // A reset held during ENTER/RET must suppress the pending write and redirect.
    if (rstn && (state == ENTER)) begin
      csr_we         = 1'b1;
      mepc_din       = lat_pc;
      mcause_din     = lat_code;
      mtval_din      = lat_tval;
      mipd_din       = 32'h0;
      redirect_valid = 1'b1;
      flush          = 1'b1;
      redirect_pc    = {mtevc_dout[31:2], 2'b00};
    end else if (rstn && (state == RET)) begin
      csr_we         = 1'b1;
      mipd_din       = 32'h1;
      redirect_valid = 1'b1;
      flush          = 1'b1;
      redirect_pc    = mepc_dout;
    end
  end

  assign busy       = (state == ENTER) || (state == RET);
  assign in_handler = (state == HANDLER);

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - table-driven bench for trap_ctrl with a behavioural CSR unit
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        exc_ebreak, exc_div0, exc_mem;
  logic [31:0] exc_pc, exc_tval;
  logic        mret, sw_we;
  logic [11:0] sw_addr;
  logic [31:0] sw_wdata;
  logic        csr_we, redirect_valid, flush, busy, in_handler;
  logic [31:0] mtevc_din, mcause_din, mepc_din, mtval_din, mipd_din, redirect_pc;
  logic [7:0]  drop_cnt;

  logic [31:0] r_tevc = '0, r_cause = '0, r_epc = '0, r_tval = '0, r_ipd = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (csr_we) begin
      r_tevc  <= mtevc_din;
      r_cause <= mcause_din;
      r_epc   <= mepc_din;
      r_tval  <= mtval_din;
      r_ipd   <= mipd_din;
    end
  end

  trap_ctrl #(.DROP_W(8)) dut (
    .clk(clk), .rstn(rstn),
    .exc_ebreak(exc_ebreak), .exc_div0(exc_div0), .exc_mem(exc_mem),
    .exc_pc(exc_pc), .exc_tval(exc_tval), .mret(mret),
    .sw_we(sw_we), .sw_addr(sw_addr), .sw_wdata(sw_wdata),
    .mtevc_dout(r_tevc), .mcause_dout(r_cause), .mepc_dout(r_epc),
    .mtval_dout(r_tval), .mipd_dout(r_ipd),
    .csr_we(csr_we), .mtevc_din(mtevc_din), .mcause_din(mcause_din),
    .mepc_din(mepc_din), .mtval_din(mtval_din), .mipd_din(mipd_din),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .busy(busy), .in_handler(in_handler), .drop_cnt(drop_cnt)
  );

  typedef struct {
    string       name;
    logic [2:0]  exc;   // {mem, div0, ebreak}
    logic [31:0] pc, tval;
    logic        mret, sw;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [4:0]  flags; // {csr_we, redirect_valid, flush, busy, in_handler}
    logic [31:0] rpc, tevc, cause, epc, tv, ipd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic [2:0] exc, input logic [31:0] pc, tval,
                     input logic m, s, input logic [11:0] a, input logic [31:0] wd,
                     input logic [4:0] fl, input logic [31:0] rpc, tevc, cause, epc, tv, ipd);
    vec_t v;
    v.name = nm; v.exc = exc; v.pc = pc; v.tval = tval; v.mret = m; v.sw = s;
    v.addr = a; v.wdata = wd; v.flags = fl; v.rpc = rpc; v.tevc = tevc;
    v.cause = cause; v.epc = epc; v.tv = tv; v.ipd = ipd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] exc, input logic [31:0] pc, tval,
                       input logic m, s, input logic [11:0] a, input logic [31:0] wd);
    {exc_mem, exc_div0, exc_ebreak} = exc;
    exc_pc = pc; exc_tval = tval; mret = m; sw_we = s; sw_addr = a; sw_wdata = wd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0;
    drive(3'b000, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_flags", {27'd0, csr_we, redirect_valid, flush, busy, in_handler}, 32'h0);
    chk("rst_rpc", redirect_pc, 32'h0);
    chk("rst_drop", {24'd0, drop_cnt}, 32'h0);
    next_cycle();
    rstn = 1'b1;

    add("sw_tevc",    3'b000, 0, 0, 0, 1, 12'h305, 32'h1003, 5'b10000, 0,     32'h1003, 0, 0, 0, 0);
    add("mret_idle",  3'b000, 0, 0, 1, 0, 0, 0,              5'b00000, 0,     32'h1003, 0, 0, 0, 0);
    add("exc_div0",   3'b010, 32'h200, 7, 0, 0, 0, 0,        5'b00000, 0,     32'h1003, 0, 0, 0, 0);
    add("enter_div0", 3'b000, 0, 0, 0, 0, 0, 0,              5'b11110, 32'h1000, 32'h1003, 2, 32'h200, 7, 0);
    add("handler",    3'b000, 0, 0, 0, 0, 0, 0,              5'b00001, 0,     32'h1003, 2, 32'h200, 7, 0);
    add("h_sw_mepc",  3'b000, 0, 0, 0, 1, 12'h341, 32'h204,  5'b10001, 0,     32'h1003, 2, 32'h204, 7, 0);
    add("h_mret_sw",  3'b000, 0, 0, 1, 1, 12'h343, 32'h55,   5'b10001, 0,     32'h1003, 2, 32'h204, 32'h55, 0);
    add("ret",        3'b000, 0, 0, 0, 0, 0, 0,              5'b11110, 32'h204, 32'h1003, 2, 32'h204, 32'h55, 1);
    add("exc_all_sw", 3'b111, 32'h300, 9, 0, 1, 12'h342, 32'hAA, 5'b00000, 0,  32'h1003, 2, 32'h204, 32'h55, 1);
    add("enter_all",  3'b000, 0, 0, 0, 0, 0, 0,              5'b11110, 32'h1000, 32'h1003, 3, 32'h300, 9, 0);
    add("h_sw_mipd",  3'b000, 0, 0, 0, 1, 12'h100, 5,        5'b10001, 0,     32'h1003, 3, 32'h300, 9, 5);
    add("h_sw_bad",   3'b000, 0, 0, 0, 1, 12'h7C0, 32'h1234, 5'b00001, 0,     32'h1003, 3, 32'h300, 9, 5);
    add("h_mret",     3'b000, 0, 0, 1, 0, 0, 0,              5'b00001, 0,     32'h1003, 3, 32'h300, 9, 5);
    add("ret2",       3'b000, 0, 0, 0, 0, 0, 0,              5'b11110, 32'h300, 32'h1003, 3, 32'h300, 9, 1);
    add("b2b_ebreak", 3'b001, 32'h400, 1, 0, 0, 0, 0,        5'b00000, 0,     32'h1003, 3, 32'h300, 9, 1);
    add("enter_ebrk", 3'b000, 0, 0, 0, 0, 0, 0,              5'b11110, 32'h1000, 32'h1003, 1, 32'h400, 1, 0);
    add("h_bad_addr", 3'b000, 0, 0, 0, 1, 12'h7C0, 32'h99,   5'b00001, 0,     32'h1003, 1, 32'h400, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].exc, vecs[i].pc, vecs[i].tval, vecs[i].mret, vecs[i].sw,
            vecs[i].addr, vecs[i].wdata);
      @(negedge clk);
      chk({vecs[i].name, ".flags"}, {27'd0, csr_we, redirect_valid, flush, busy, in_handler},
          {27'd0, vecs[i].flags});
      chk({vecs[i].name, ".rpc"},   redirect_pc, vecs[i].rpc);
      chk({vecs[i].name, ".tevc"},  mtevc_din,   vecs[i].tevc);
      chk({vecs[i].name, ".cause"}, mcause_din,  vecs[i].cause);
      chk({vecs[i].name, ".epc"},   mepc_din,    vecs[i].epc);
      chk({vecs[i].name, ".tval"},  mtval_din,   vecs[i].tv);
      chk({vecs[i].name, ".ipd"},   mipd_din,    vecs[i].ipd);
      next_cycle();
    end
    chk("tevc_model", r_tevc, 32'h1003);
    chk("drop_before", {24'd0, drop_cnt}, 32'h0);

    // 300 dropped exceptions in HANDLER: counter saturates, no writes, no state change
    begin
      int bad = 0;
      for (int i = 0; i < 300; i++) begin
        drive(3'b100, 32'h600, 32'h6, 0, 0, 0, 0);
        @(negedge clk);
        if (csr_we || !in_handler || redirect_valid) bad++;
        next_cycle();
      end
      chk("drop_no_write", bad, 0);
    end
    drive(3'b000, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("drop_sat", {24'd0, drop_cnt}, 32'd255);
    chk("drop_in_handler", {31'd0, in_handler}, 32'd1);
    next_cycle();

    drive(3'b000, 0, 0, 0, 1, 12'h341, 32'h204);
    next_cycle();
    drive(3'b000, 0, 0, 1, 0, 0, 0);
    next_cycle();
    @(negedge clk);
    chk("ret_epc_rpc", redirect_pc, 32'h204);
    chk("ret_ipd", mipd_din, 32'h1);
    chk("ret_rv", {31'd0, redirect_valid}, 32'd1);
    next_cycle();
    drive(3'b000, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("idle_after_ret", {30'd0, busy, in_handler}, 32'd0);
    chk("ipd_model", r_ipd, 32'h1);
    next_cycle();

    // reset asserted while in ENTER: trap write is suppressed
    drive(3'b010, 32'h500, 32'h8, 0, 0, 0, 0);
    next_cycle();
    drive(3'b000, 0, 0, 0, 0, 0, 0);
    rstn = 1'b0;
    @(negedge clk);
    chk("rst_enter_we", {29'd0, csr_we, redirect_valid, flush}, 32'd0);
    chk("rst_enter_rpc", redirect_pc, 32'h0);
    next_cycle();
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_enter_state", {30'd0, busy, in_handler}, 32'd0);
    chk("rst_enter_epc", r_epc, 32'h204);
    chk("rst_enter_drop", {24'd0, drop_cnt}, 32'd0);
    drive(3'b000, 0, 0, 0, 1, 12'h7C0, 32'hDEAD);
    @(negedge clk);
    chk("idle_bad_addr", {31'd0, csr_we}, 32'd0);
    next_cycle();
    drive(3'b000, 0, 0, 0, 1, 12'h305, 32'h2000);
    @(negedge clk);
    chk("idle_sw_we", {31'd0, csr_we}, 32'd1);
    next_cycle();
    drive(3'b000, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("idle_sw_visible", r_tevc, 32'h2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Trap sequencer directly upstream of the CSR unit: it turns exception requests, `mret` and CSR-instruction writes into the CSR unit's single write-enable and its five data-in buses. On trap entry it redirects the fetch PC to the handler and flushes the pipeline. It sits between the execute/memory stages and the CSR unit, and drives `mipd` so software can poll for handler completion. Because the CSR unit writes all five registers on one `csr_we`, every unchanged register is re-driven from its `*_dout` on every write cycle.

## Interface
- `DROP_W`, default 8: width of the dropped-exception counter.
- `clk` in 1: system clock, rising edge.
- `rstn` in 1: synchronous reset, active low.
- `exc_ebreak` in 1: user interrupt (ebreak) request; cause code 1.
- `exc_div0` in 1: divide-by-zero request; cause code 2.
- `exc_mem` in 1: memory access error request; cause code 3.
- `exc_pc` in 32: PC of the faulting instruction.
- `exc_tval` in 32: trap value (faulting address or operand).
- `mret` in 1: return-from-handler strobe.
- `sw_we` in 1: CSR instruction write strobe.
- `sw_addr` in 12: CSR address for `sw_we`.
- `sw_wdata` in 32: CSR write data.
- `mtevc_dout`, `mcause_dout`, `mepc_dout`, `mtval_dout`, `mipd_dout` in 32 each: current CSR values from the CSR unit.
- `csr_we` out 1: CSR unit write enable.
- `mtevc_din`, `mcause_din`, `mepc_din`, `mtval_din`, `mipd_din` out 32 each: CSR unit data-in buses.
- `redirect_valid` out 1: fetch must load `redirect_pc` this cycle.
- `redirect_pc` out 32: PC redirect target.
- `flush` out 1: kill all in-flight instructions.
- `busy` out 1: high in ENTER and RET.
- `in_handler` out 1: high in HANDLER.
- `drop_cnt` out DROP_W: count of exceptions ignored while in HANDLER.

## Operation
- States:
  - IDLE: normal execution.
  - ENTER: one cycle; performs the trap write and the redirect.
  - HANDLER: the trap handler is running.
  - RET: one cycle; performs the return write and the redirect.
- Default drive, every cycle: each `*_din` equals its `*_dout`; `csr_we`, `redirect_valid` and `flush` are 0.
- Exception priority: `exc_mem` > `exc_div0` > `exc_ebreak`.

IDLE:
- Any `exc_*` high: latch the cause code (zero-extended to 32 bits), `exc_pc` and `exc_tval`; go to ENTER.
- Else, if `sw_we` is high: perform the software write (below).
- `mret` in IDLE is ignored.

Software write, combinational in the same cycle:
- `csr_we` = 1; only the targeted `*_din` takes `sw_wdata`.
- Addresses: 0x305 mtevc, 0x342 mcause, 0x341 mepc, 0x343 mtval, 0x100 mipd.
- Any other address: `csr_we` stays 0 (write ignored).

ENTER:
- `csr_we` = 1.
- `mepc_din` = latched pc; `mcause_din` = latched code; `mtval_din` = latched tval; `mipd_din` = 0; `mtevc_din` = `mtevc_dout`.
- `redirect_valid` = 1; `flush` = 1; `redirect_pc` = {`mtevc_dout[31:2]`, 2'b00}.
- Next state: HANDLER.
- `sw_we`, `mret` and `exc_*` are ignored.

HANDLER:
- `sw_we` is serviced as in IDLE.
- `mret` high: go to RET. If `sw_we` is high in the same cycle, the software write is still performed that cycle.
- Any `exc_*` high: not taken; `drop_cnt` increments, saturating at all-ones.

RET:
- `csr_we` = 1; `mipd_din` = 32'h1; all other buses mirror their `dout`.
- `redirect_valid` = 1; `flush` = 1; `redirect_pc` = `mepc_dout`. The handler advances mepc itself if required.
- Next state: IDLE.
- All inputs are ignored.

`redirect_pc` is 0 whenever `redirect_valid` is 0.

## Timing
- Reset (`rstn` = 0 at a rising edge): next cycle state = IDLE, latches = 0, `drop_cnt` = 0. `csr_we`, `redirect_valid`, `flush`, `busy`, `in_handler` and `redirect_pc` read 0. Buses mirror `dout`.
- Reset overrides any state, including mid-ENTER or mid-RET; the pending write is not performed.
- Exception sampled at edge N (cycle N in IDLE) → ENTER in cycle N+1 (write and redirect asserted) → new CSR values visible at CSR `dout` in cycle N+2, state HANDLER.
- `mret` in cycle M → RET in cycle M+1 → `mipd` reads 1 and state is IDLE in cycle M+2.
- Software write: zero added latency; the value is visible at `dout` the next cycle.
- Back-to-back: a new exception is accepted in the first IDLE cycle after RET.
- Exception and `sw_we` in the same IDLE cycle: the software write is dropped.

## Test plan
- Reset, then `sw_we`, addr 0x305, data 0x0000_1003 → `csr_we` = 1 that cycle, `mtevc_din` = 0x1003, other buses = their douts; next cycle `mtevc_dout` = 0x1003.
- Hold `exc_div0` one cycle with `exc_pc` = 0x200, `exc_tval` = 0x7 → next cycle `csr_we` = 1, `mepc_din` = 0x200, `mcause_din` = 2, `mtval_din` = 7, `mipd_din` = 0, `redirect_pc` = 0x1000, `flush` = 1; the cycle after, `in_handler` = 1.
- `exc_ebreak`, `exc_div0` and `exc_mem` all high together in IDLE → `mcause_din` = 3 in ENTER.
- In HANDLER, pulse `exc_mem` 300 times → `drop_cnt` = 255, state unchanged, no `csr_we` from those pulses.
- `mret` in HANDLER with `mepc_dout` = 0x204 → next cycle `mipd_din` = 1, `redirect_pc` = 0x204, `redirect_valid` = 1; then IDLE.
- Drop `rstn` during ENTER → no CSR write and state IDLE next cycle; `sw_we` to 0x7C0 in IDLE → `csr_we` stays 0.
